// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the RV32I core.
// Handles CSR access, trap entry/exit, interrupt priority and counters.
module csr_trap_unit #(
    parameter int NUM_LIRQ = 4,
    parameter bit VEC_EN   = 1'b1,
    parameter int CNT_W    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csr_en,
    input  logic [1:0]          csr_op,
    input  logic [11:0]         csr_adr,
    input  logic [31:0]         csr_wdata,
    output logic [31:0]         csr_rdata,
    input  logic                exc_valid,
    input  logic [3:0]          exc_code,
    input  logic [29:0]         exc_pc,
    input  logic [31:0]         exc_tval,
    input  logic                irq_boundary,
    input  logic [29:0]         irq_pc,
    input  logic                irq_meip,
    input  logic                irq_mtip,
    input  logic                irq_msip,
    input  logic [NUM_LIRQ-1:0] irq_local,
    input  logic                retire,
    input  logic                mret,
    output logic                trap_take,
    output logic [29:0]         trap_vec,
    output logic [29:0]         mepc_out,
    output logic                irq_pending
);

    localparam logic [31:0] MIE_MASK =
        32'h0000_0888 | (((32'h1 << NUM_LIRQ) - 32'h1) << 16);

    logic                r_mie_bit;
    logic                r_mpie;
    logic [31:0]         r_mie;
    logic [29:0]         r_mtvec_base;
    logic                r_mtvec_mode;
    logic [1:0]          r_inhibit;
    logic [29:0]         r_mepc;
    logic [31:0]         r_mcause;
    logic [31:0]         r_mtval;
    logic                r_meip;
    logic                r_mtip;
    logic                r_msip;
    logic [NUM_LIRQ-1:0] r_lirq;
    logic [CNT_W-1:0]    r_mcycle;
    logic [CNT_W-1:0]    r_minstret;

    logic [31:0] w_mip;
    logic [31:0] w_act;
    logic [31:0] w_wval;
    logic        w_wr;
    logic        w_irq_req;
    logic [4:0]  w_irq_code;
    logic [63:0] w_cyc64;
    logic [63:0] w_ins64;

    assign w_cyc64 = 64'(r_mcycle);
    assign w_ins64 = 64'(r_minstret);

    // Assemble the pending-interrupt view from the registered lines
    always_comb begin
        w_mip = 32'h0;
        w_mip[11] = r_meip;
        w_mip[7] = r_mtip;
        w_mip[3] = r_msip;
        w_mip[16 +: NUM_LIRQ] = r_lirq;
    end

    assign w_act       = w_mip & r_mie;
    assign irq_pending = |w_act;
    assign w_irq_req   = r_mie_bit & irq_boundary & irq_pending;
    assign trap_take   = exc_valid | w_irq_req;
    assign mepc_out    = r_mepc;

    // Fixed priority: later assignments win, so the highest local line is top
    always_comb begin
        w_irq_code = 5'd0;
        if (w_act[7])  w_irq_code = 5'd7;
        if (w_act[3])  w_irq_code = 5'd3;
        if (w_act[11]) w_irq_code = 5'd11;
        for (int i = 0; i < NUM_LIRQ; i++) begin
            if (w_act[16+i]) w_irq_code = 5'(16 + i);
        end
    end

    // Trap target: vectored only for interrupts with mode 1
    always_comb begin
        trap_vec = r_mtvec_base;
        if (!exc_valid && r_mtvec_mode)
            trap_vec = r_mtvec_base + 30'(w_irq_code);
    end

    // CSR read mux; unmapped addresses read zero
    always_comb begin
        case (csr_adr)
            12'h300: csr_rdata = {19'h0, 2'b11, 3'h0, r_mpie,
                                  3'h0, r_mie_bit, 3'h0};
            12'h304: csr_rdata = r_mie;
            12'h305: csr_rdata = {r_mtvec_base, 1'b0, r_mtvec_mode};
            12'h320: csr_rdata = {29'h0, r_inhibit[1], 1'b0, r_inhibit[0]};
            12'h341: csr_rdata = {r_mepc, 2'b00};
            12'h342: csr_rdata = r_mcause;
            12'h343: csr_rdata = r_mtval;
            12'h344: csr_rdata = w_mip;
            12'hB00: csr_rdata = w_cyc64[31:0];
            12'hB80: csr_rdata = w_cyc64[63:32];
            12'hB02: csr_rdata = w_ins64[31:0];
            12'hB82: csr_rdata = w_ins64[63:32];
            default: csr_rdata = 32'h0;
        endcase
    end

    // Read-modify-write value for RW/RS/RC
    always_comb begin
        case (csr_op)
            2'b01:   w_wval = csr_wdata;
            2'b10:   w_wval = csr_rdata | csr_wdata;
            2'b11:   w_wval = csr_rdata & ~csr_wdata;
            default: w_wval = csr_rdata;
        endcase
    end

    assign w_wr = csr_en & (csr_op != 2'b00) & ~trap_take;

    // Trap entry, mret and CSR writes to the control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie_bit    <= 1'b0;
            r_mpie       <= 1'b0;
            r_mie        <= 32'h0;
            r_mtvec_base <= 30'h0;
            r_mtvec_mode <= 1'b0;
            r_inhibit    <= 2'b00;
            r_mepc       <= 30'h0;
            r_mcause     <= 32'h0;
            r_mtval      <= 32'h0;
        end else if (trap_take) begin
            r_mepc    <= exc_valid ? exc_pc : irq_pc;
            r_mcause  <= exc_valid ? {28'h0, exc_code}
                                   : {1'b1, 26'h0, w_irq_code};
            r_mtval   <= exc_valid ? exc_tval : 32'h0;
            r_mpie    <= r_mie_bit;
            r_mie_bit <= 1'b0;
        end else begin
            if (mret) begin
                r_mie_bit <= r_mpie;
                r_mpie    <= 1'b1;
            end
            if (w_wr) begin
                case (csr_adr)
                    12'h300: begin
                        r_mie_bit <= w_wval[3];
                        r_mpie    <= w_wval[7];
                    end
                    12'h304: r_mie <= w_wval & MIE_MASK;
                    12'h305: begin
                        r_mtvec_base <= w_wval[31:2];
                        r_mtvec_mode <= VEC_EN & w_wval[0];
                    end
                    12'h320: r_inhibit <= {w_wval[2], w_wval[0]};
                    12'h341: r_mepc <= w_wval[31:2];
                    12'h342: r_mcause <= w_wval;
                    12'h343: r_mtval <= w_wval;
                    default: ;
                endcase
            end
        end
    end

    // One-cycle registered copy of the interrupt lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meip <= 1'b0;
            r_mtip <= 1'b0;
            r_msip <= 1'b0;
            r_lirq <= '0;
        end else begin
            r_meip <= irq_meip;
            r_mtip <= irq_mtip;
            r_msip <= irq_msip;
            r_lirq <= irq_local;
        end
    end

    // Cycle counter: a write to either half suppresses the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mcycle <= '0;
        else if (w_wr && csr_adr == 12'hB00)
            r_mcycle[31:0] <= w_wval;
        else if (w_wr && csr_adr == 12'hB80)
            r_mcycle[CNT_W-1:32] <= w_wval[CNT_W-33:0];
        else if (!r_inhibit[0])
            r_mcycle <= r_mcycle + 1'b1;
    end

    // Retired-instruction counter, same write rules as mcycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_minstret <= '0;
        else if (w_wr && csr_adr == 12'hB02)
            r_minstret[31:0] <= w_wval;
        else if (w_wr && csr_adr == 12'hB82)
            r_minstret[CNT_W-1:32] <= w_wval[CNT_W-33:0];
        else if (retire && !r_inhibit[1])
            r_minstret <= r_minstret + 1'b1;
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit.
// Drives 1 ns after the rising edge and samples before the next one.
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_adr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [29:0] exc_pc;
    logic [31:0] exc_tval;
    logic        irq_boundary;
    logic [29:0] irq_pc;
    logic        irq_meip;
    logic        irq_mtip;
    logic        irq_msip;
    logic [3:0]  irq_local;
    logic        retire;
    logic        mret;
    logic        trap_take;
    logic [29:0] trap_vec;
    logic [29:0] mepc_out;
    logic        irq_pending;

    int n_chk = 0;
    int n_fail = 0;

    csr_trap_unit #(.NUM_LIRQ(4), .VEC_EN(1'b1), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_en(csr_en), .csr_op(csr_op), .csr_adr(csr_adr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_tval(exc_tval), .irq_boundary(irq_boundary), .irq_pc(irq_pc),
        .irq_meip(irq_meip), .irq_mtip(irq_mtip), .irq_msip(irq_msip),
        .irq_local(irq_local), .retire(retire), .mret(mret),
        .trap_take(trap_take), .trap_vec(trap_vec), .mepc_out(mepc_out),
        .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] adr,
                          input logic [31:0] d);
        csr_en = 1'b1;
        csr_op = op;
        csr_adr = adr;
        csr_wdata = d;
        tick();
        csr_en = 1'b0;
        csr_op = 2'b00;
    endtask

    task automatic rd(input string tag, input logic [11:0] adr,
                      input logic [31:0] exp);
        csr_adr = adr;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        csr_en = 1'b0; csr_op = 2'b00; csr_adr = 12'h0; csr_wdata = 32'h0;
        exc_valid = 1'b0; exc_code = 4'h0; exc_pc = 30'h0; exc_tval = 32'h0;
        irq_boundary = 1'b0; irq_pc = 30'h0;
        irq_meip = 1'b0; irq_mtip = 1'b0; irq_msip = 1'b0;
        irq_local = 4'h0; retire = 1'b0; mret = 1'b0;
        tick();
        tick();
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mtvec", 12'h305, 32'h0);
        chk("rst_trap", {31'h0, trap_take}, 32'h0);
        chk("rst_pend", {31'h0, irq_pending}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Vectored timer interrupt
        csr_wr(2'b01, 12'h305, 32'h0000_1001);
        rd("mtvec", 12'h305, 32'h0000_1001);
        csr_wr(2'b01, 12'h304, 32'h0000_0080);
        csr_wr(2'b01, 12'h300, 32'h0000_0008);
        rd("mstatus_mie", 12'h300, 32'h0000_1808);
        irq_mtip = 1'b1;
        tick();
        rd("mip_mtip", 12'h344, 32'h0000_0080);
        chk("pend_mtip", {31'h0, irq_pending}, 32'h1);
        irq_boundary = 1'b1;
        irq_pc = 30'h123;
        #1;
        chk("take_mti", {31'h0, trap_take}, 32'h1);
        chk("vec_mti", {2'b0, trap_vec}, 32'h0000_0407);
        tick();
        irq_boundary = 1'b0;
        irq_mtip = 1'b0;
        rd("mcause_mti", 12'h342, 32'h8000_0007);
        rd("mstatus_trap", 12'h300, 32'h0000_1880);
        rd("mepc_mti", 12'h341, 32'h0000_048C);
        chk("mepc_out", {2'b0, mepc_out}, 32'h0000_0123);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        rd("mstatus_mret", 12'h300, 32'h0000_1888);

        // Exception beats simultaneous interrupts
        csr_wr(2'b01, 12'h304, 32'h0008_0880);
        irq_local = 4'b1000;
        irq_meip = 1'b1;
        tick();
        exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 30'h200;
        exc_tval = 32'hDEAD_BEEF;
        irq_boundary = 1'b1; irq_pc = 30'h300;
        #1;
        chk("take_exc", {31'h0, trap_take}, 32'h1);
        chk("vec_exc", {2'b0, trap_vec}, 32'h0000_0400);
        tick();
        exc_valid = 1'b0;
        irq_boundary = 1'b0;
        rd("mcause_exc", 12'h342, 32'h0000_0002);
        rd("mtval_exc", 12'h343, 32'hDEAD_BEEF);
        rd("mepc_exc", 12'h341, 32'h0000_0800);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        irq_boundary = 1'b1;
        #1;
        chk("take_loc", {31'h0, trap_take}, 32'h1);
        chk("vec_loc", {2'b0, trap_vec}, 32'h0000_0413);
        tick();
        irq_boundary = 1'b0;
        irq_local = 4'h0;
        irq_meip = 1'b0;
        rd("mcause_loc", 12'h342, 32'h8000_0013);
        rd("mtval_loc", 12'h343, 32'h0);
        rd("mepc_loc", 12'h341, 32'h0000_0C00);

        // mret collides with exception: trap wins
        mret = 1'b1;
        tick();
        rd("mstatus_mret2", 12'h300, 32'h0000_1888);
        exc_valid = 1'b1; exc_code = 4'd11; exc_tval = 32'h0;
        tick();
        mret = 1'b0;
        exc_valid = 1'b0;
        rd("mstatus_mret_exc", 12'h300, 32'h0000_1880);

        // CSR write dropped when a trap is taken in the same cycle
        exc_valid = 1'b1; exc_code = 4'd3; exc_tval = 32'h66;
        csr_wr(2'b01, 12'h343, 32'h55);
        exc_valid = 1'b0;
        rd("mtval_trapwr", 12'h343, 32'h0000_0066);

        // RS/RC on mie, unmapped address
        csr_wr(2'b01, 12'h304, 32'h0);
        csr_wr(2'b10, 12'h304, 32'h0001_0888);
        rd("mie_rs", 12'h304, 32'h0001_0888);
        csr_wr(2'b11, 12'h304, 32'h0000_0800);
        rd("mie_rc", 12'h304, 32'h0001_0088);
        csr_wr(2'b01, 12'h7C0, 32'hFFFF_FFFF);
        rd("unmapped", 12'h7C0, 32'h0);

        // mcycle carry into upper half
        csr_wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        csr_wr(2'b01, 12'hB80, 32'h0);
        rd("mcycle_lo0", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycle_hi0", 12'hB80, 32'h0);
        tick();
        rd("mcycle_lo1", 12'hB00, 32'h0);
        rd("mcycle_hi1", 12'hB80, 32'h1);

        // Inhibit freezes counters
        csr_wr(2'b01, 12'h320, 32'hFFFF_FFFF);
        rd("inhibit", 12'h320, 32'h0000_0005);
        csr_wr(2'b01, 12'hB00, 32'h1234_5678);
        repeat (5) tick();
        rd("mcycle_frozen", 12'hB00, 32'h1234_5678);
        csr_wr(2'b01, 12'h320, 32'h0);
        csr_wr(2'b01, 12'hB00, 32'h0000_0100);
        rd("mcycle_wr", 12'hB00, 32'h0000_0100);
        tick();
        rd("mcycle_inc", 12'hB00, 32'h0000_0101);

        // minstret counts retirements
        csr_wr(2'b01, 12'hB02, 32'h0);
        retire = 1'b1;
        repeat (3) tick();
        retire = 1'b0;
        tick();
        rd("minstret", 12'hB02, 32'h3);

        // Asynchronous reset mid-operation
        csr_wr(2'b01, 12'h305, 32'h0000_2001);
        csr_wr(2'b01, 12'h300, 32'h0000_0088);
        #2;
        rst_n = 1'b0;
        #1;
        rd("rr_mtvec", 12'h305, 32'h0);
        rd("rr_mstatus", 12'h300, 32'h0000_1800);
        rd("rr_mie", 12'h304, 32'h0);
        rd("rr_mcause", 12'h342, 32'h0);
        rd("rr_mtval", 12'h343, 32'h0);
        rd("rr_mcycle", 12'hB00, 32'h0);
        rd("rr_minstret", 12'hB02, 32'h0);
        chk("rr_mepc", {2'b0, mepc_out}, 32'h0);
        chk("rr_pend", {31'h0, irq_pending}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
